branch_resolve_unit: RTL
========================

# branch_resolve_unit

Decode-stage branch resolution unit: the consumer end of the IF-stage dynamic branch predictor interface. It evaluates each conditional branch held in IF/ID against the flags or register operand, compares the outcome with the IF/ID prediction and predicted target, and drives the predictor update strobes (`wen_BHT`, `wen_BTB`, `actual_taken`, `actual_target`) and the PC redirect. It also owns the flag and register hazard stall for branches and makes sure each branch updates the predictor exactly once, even while IF/ID is held.

## Interface
- `STATS_W`, default 16: width of the statistics counters; used only with `BRU_STATS_EN`.
- `clk`  in  1  clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `enable`  in  1  pipeline advance. IF/ID loads on the next edge when high.
- `is_branch`  in  1  IF/ID holds a B or BR instruction.
- `is_br_reg`  in  1  1 = BR (target taken from register), 0 = B (PC-relative).
- `ccc`  in  3  condition code field.
- `imm9`  in  9  signed word offset for B.
- `rs_data`  in  16  register target for BR.
- `rs_pending`  in  1  an in-flight instruction writes the BR source register.
- `flags`  in  3  {Z,V,N} from the flag register.
- `flags_pending`  in  1  an in-flight instruction updates the flags.
- `IF_ID_PC_curr`  in  16  PC of the instruction in IF/ID.
- `IF_ID_prediction`  in  2  predictor counter captured at fetch. Bit 1 = predicted taken.
- `IF_ID_predicted_target`  in  16  target captured at fetch.
- `actual_taken`  out  1  resolved direction.
- `actual_target`  out  16  resolved taken target. 0x0000 when not taken.
- `wen_BHT`  out  1  BHT update strobe.
- `wen_BTB`  out  1  BTB update strobe.
- `update_PC`  out  1  redirect fetch to `redirect_PC`.
- `redirect_PC`  out  16  correct next fetch address.
- `IF_ID_flush`  out  1  squash the wrong-path instruction in IF/ID.
- `branch_stall`  out  1  hold PC and IF/ID (hazard).

## Operation
- Condition evaluation, `ccc` to taken:
  - 000 NEQ: !Z.
  - 001 EQ: Z.
  - 010 GT: !Z & !N.
  - 011 LT: N.
  - 100 GTE: Z | !N.
  - 101 LTE: N | Z.
  - 110 OVFL: V.
  - 111 UNCOND: always taken.
- Target and next-PC arithmetic (all 16-bit, wraps mod 2^16):
  - B target: `IF_ID_PC_curr + 2 + (sext(imm9) << 1)`.
  - BR target: `rs_data`.
  - Fall-through address: `IF_ID_PC_curr + 2`.
- Outputs in the resolve cycle; `mispredicted` = `IF_ID_prediction[1] != taken`, `miscomputed` = `IF_ID_predicted_target != target`:
  - `wen_BHT` = `mispredicted`.
  - `wen_BTB` = `taken | miscomputed`.
  - `update_PC` = `taken ? (mispredicted | miscomputed) : IF_ID_prediction[1]`.
  - `redirect_PC` = `taken ? target : PC+2`.
  - `IF_ID_flush` = `update_PC`.
- State machine:
  - IDLE:
    - No branch: all strobes 0.
    - Branch with hazard (`flags_pending` and `ccc` != 111, or `is_br_reg & rs_pending`): go to HAZARD.
    - Branch, no hazard: resolve this cycle. If `enable` = 0, go to DONE; otherwise stay in IDLE.
  - HAZARD:
    - `branch_stall` = 1; all strobes 0.
    - When the hazard clears: resolve in the same cycle, then go to DONE if `enable` = 0, else IDLE.
  - DONE:
    - Branch already resolved, IF/ID still held. All strobes 0.
    - `enable` = 1: go to IDLE.
- Outside the resolve cycle: `actual_taken`, `actual_target` and `redirect_PC` are 0.

## Timing
- Resolution is combinational from inputs within the resolve cycle. Predictor memories write on the following posedge.
- Reset (asynchronous, `rst_n` low): state = IDLE, counters = 0, every output = 0. When reset is asserted mid-HAZARD or in DONE, no strobe fires.
- `branch_stall` and `enable` = 0 in the same cycle: `branch_stall` has priority; state stays HAZARD.
- `is_branch` dropping while in HAZARD (IF/ID flushed from downstream): return to IDLE next cycle, no strobes.
- A strobe never fires twice for the same IF/ID contents.

## Configuration
- `BRU_STATS_EN` defined: adds output ports `stat_branches` and `stat_mispredicts` (both `STATS_W`, saturating).
  - `stat_branches` increments on every resolve cycle.
  - `stat_mispredicts` increments when `update_PC` = 1.
  - Both reset to 0.
- `BRU_STATS_EN` undefined: the ports and counters are absent. All other behaviour is identical.

## Structure
- `branch_pkg` holds:
  - the `ccc_t` enum (NEQ..UNCOND),
  - the `bru_state_t` enum (IDLE, HAZARD, DONE),
  - the `PC_INC = 16'h0002` constant.
- Sub-module `branch_cond_eval`: combinational `ccc` + `flags` to `taken`. It is reused by the reference model.

## Test plan
- No branch prediction, B with `ccc`=111, `imm9`=0x004, PC=0x0010, prediction=00, enable=1 -> `actual_taken`=1, `actual_target`=0x001A, `wen_BHT`=1, `wen_BTB`=1, `update_PC`=1, `IF_ID_flush`=1.
- B with EQ, Z=0, prediction=10, PC=0x0020 -> `actual_taken`=0, `actual_target`=0x0000, `wen_BHT`=1, `wen_BTB`=0, `update_PC`=1, `redirect_PC`=0x0022.
- Correct prediction: BR with `rs_data`=0x1234, prediction=11, predicted target=0x1234 -> `wen_BTB`=1, `wen_BHT`=0, `update_PC`=0.
- `flags_pending`=1 for 2 cycles on a GT branch -> `branch_stall`=1 for 2 cycles, no strobes, resolve on cycle 3.
- Branch resolves with `enable`=0 held 3 cycles -> strobes exactly once, DONE for 3 cycles, IDLE after `enable`=1.
- `rst_n` low while in HAZARD -> all outputs 0 immediately; after release, state is IDLE and with `BRU_STATS_EN` the counters read 0.

Source files
------------

// File: rtl/branch_pkg.sv
// ---------------------------------------------------------------------------
// branch_pkg
// Shared types and constants for the decode-stage branch resolution unit.
//   ccc_t       : condition-code field encodings of B/BR instructions
//   bru_state_t : resolution state machine states
//   PC_INC      : instruction size in bytes (fall-through increment)
// ---------------------------------------------------------------------------
package branch_pkg;

  typedef enum logic [2:0] {
    NEQ    = 3'b000,
    EQ     = 3'b001,
    GT     = 3'b010,
    LT     = 3'b011,
    GTE    = 3'b100,
    LTE    = 3'b101,
    OVFL   = 3'b110,
    UNCOND = 3'b111
  } ccc_t;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    HAZARD = 2'b01,
    DONE   = 2'b10
  } bru_state_t;

  localparam logic [15:0] PC_INC = 16'h0002;

endpackage

// File: rtl/branch_cond_eval.sv
// ---------------------------------------------------------------------------
// branch_cond_eval
// Combinational condition evaluation for conditional branches.
// Ports:
//   ccc   in  [2:0] condition code field
//   flags in  [2:0] {Z,V,N} from the flag register
//   taken out       branch condition satisfied
// ---------------------------------------------------------------------------
module branch_cond_eval
  import branch_pkg::*;
(
  input  logic [2:0] ccc,
  input  logic [2:0] flags,
  output logic       taken
);

  logic z;
  logic v;
  logic n;

  assign z = flags[2];
  assign v = flags[1];
  assign n = flags[0];

  always_comb begin
    taken = 1'b0;
    case (ccc_t'(ccc))
      NEQ:     taken = ~z;
      EQ:      taken = z;
      GT:      taken = ~z & ~n;
      LT:      taken = n;
      GTE:     taken = z | ~n;
      LTE:     taken = n | z;
      OVFL:    taken = v;
      UNCOND:  taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// ---------------------------------------------------------------------------
// branch_resolve_unit
// Decode-stage branch resolution: evaluates the branch in IF/ID, compares it
// against the fetch-time prediction, drives predictor update strobes and the
// PC redirect, and stalls on flag/register hazards. Each branch updates the
// predictor exactly once even while IF/ID is held.
// Optional feature macro: BRU_STATS_EN adds saturating statistics counters.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   enable                     pipeline advance (IF/ID loads next edge)
//   is_branch, is_br_reg       branch present / register-target branch
//   ccc, imm9, rs_data         condition, B offset, BR target
//   rs_pending, flags_pending  operand hazards
//   flags                      {Z,V,N}
//   IF_ID_PC_curr              PC of the branch
//   IF_ID_prediction           2-bit counter from fetch (bit 1 = taken)
//   IF_ID_predicted_target     target from fetch
//   actual_taken/target        resolved direction and taken target
//   wen_BHT, wen_BTB           predictor update strobes
//   update_PC, redirect_PC     fetch redirect
//   IF_ID_flush, branch_stall  squash / hold IF/ID
//   stat_branches, stat_mispredicts  (BRU_STATS_EN only)
// ---------------------------------------------------------------------------
module branch_resolve_unit
  import branch_pkg::*;
#(
  parameter int STATS_W = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        is_branch,
  input  logic        is_br_reg,
  input  logic [2:0]  ccc,
  input  logic [8:0]  imm9,
  input  logic [15:0] rs_data,
  input  logic        rs_pending,
  input  logic [2:0]  flags,
  input  logic        flags_pending,
  input  logic [15:0] IF_ID_PC_curr,
  input  logic [1:0]  IF_ID_prediction,
  input  logic [15:0] IF_ID_predicted_target,
  output logic        actual_taken,
  output logic [15:0] actual_target,
  output logic        wen_BHT,
  output logic        wen_BTB,
  output logic        update_PC,
  output logic [15:0] redirect_PC,
  output logic        IF_ID_flush,
  output logic        branch_stall
`ifdef BRU_STATS_EN
  ,
  output logic [STATS_W-1:0] stat_branches,
  output logic [STATS_W-1:0] stat_mispredicts
`endif
);

  if (STATS_W < 1) begin : g_bad_stats_w
    $error("STATS_W must be at least 1");
  end

  bru_state_t  state;
  logic        taken;
  logic        hazard;
  logic        resolve;
  logic        mispredicted;
  logic        miscomputed;
  logic [15:0] target;
  logic [15:0] fall_through;

  branch_cond_eval u_cond (
    .ccc   (ccc),
    .flags (flags),
    .taken (taken)
  );

  // Unconditional branches never read the flags, so only a register target
  // can stall them.
  assign hazard = is_branch &
                  ((flags_pending & (ccc != UNCOND)) | (is_br_reg & rs_pending));

  // Reset gates the combinational outputs so nothing fires while rst_n is low.
  assign resolve      = rst_n & is_branch & ~hazard & (state != DONE);
  assign branch_stall = rst_n & hazard & (state != DONE);

  assign fall_through = IF_ID_PC_curr + PC_INC;
  assign target       = is_br_reg ? rs_data
                                  : fall_through + {{6{imm9[8]}}, imm9, 1'b0};
  assign mispredicted = IF_ID_prediction[1] != taken;
  assign miscomputed  = IF_ID_predicted_target != target;

  always_comb begin
    actual_taken  = 1'b0;
    actual_target = 16'h0000;
    wen_BHT       = 1'b0;
    wen_BTB       = 1'b0;
    update_PC     = 1'b0;
    redirect_PC   = 16'h0000;
    if (resolve) begin
      actual_taken  = taken;
      actual_target = taken ? target : 16'h0000;
      wen_BHT       = mispredicted;
      wen_BTB       = taken | miscomputed;
      update_PC     = taken ? (mispredicted | miscomputed) : IF_ID_prediction[1];
      redirect_PC   = taken ? target : fall_through;
    end
  end

  assign IF_ID_flush = update_PC;

  // DONE remembers that the held IF/ID branch already updated the predictor;
  // only a pipeline advance releases it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (is_branch) begin
            if (hazard)       state <= HAZARD;
            else if (!enable) state <= DONE;
          end
        end
        HAZARD: begin
          if (!is_branch)   state <= IDLE;
          else if (!hazard) state <= enable ? IDLE : DONE;
        end
        DONE: begin
          if (enable) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef BRU_STATS_EN
  // Saturating counters: they stick at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else begin
      if (resolve && (stat_branches != {STATS_W{1'b1}}))
        stat_branches <= stat_branches + 1'b1;
      if (update_PC && (stat_mispredicts != {STATS_W{1'b1}}))
        stat_mispredicts <= stat_mispredicts + 1'b1;
    end
  end
`endif

endmodule
